// File: rtl/c1541_rom_arbiter_pkg.sv
// Shared constants, ROM image-size encoding and address folding for the drive-ROM arbiter.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package c1541_pkg;

    localparam int         ROM_ADDR_W       = 15;
    // Top two address bits of the only region a Dolphin DOS image may rewrite (first 8 KB).
    localparam logic [1:0] DOLPHIN_WIN_BITS = 2'b00;

    // Encoded as {r32, r32|r16}; doubles as the mask applied to addr[14:13].
    typedef enum logic [1:0] {
        SZ_8K  = 2'b00,
        SZ_16K = 2'b01,
        SZ_32K = 2'b11
    } rom_size_t;

    // Smaller images are mirrored across the 32 KB window by masking the upper bits.
    function automatic logic [ROM_ADDR_W-1:0] fold_addr(input logic [ROM_ADDR_W-1:0] addr,
                                                        input logic [1:0]            rom_sz);
        return {addr[ROM_ADDR_W-1 -: 2] & rom_sz, addr[ROM_ADDR_W-3:0]};
    endfunction

endpackage

// File: rtl/c1541_rom_arbiter_if.sv
// Per-drive CPU bus bundle between the emulated 1541 CPUs and the ROM arbiter.
// Latency: n/a (wires only).
// Backpressure: drv_req is a level held until the one-cycle drv_ack pulse.
interface c1541_rom_arbiter_if #(
    parameter int NDRIVES = 4,
    parameter int ADDR_W  = 15
);
    logic [NDRIVES-1:0]        drv_req;
    logic [NDRIVES-1:0]        drv_we;
    logic [NDRIVES*ADDR_W-1:0] drv_addr;
    logic [NDRIVES*8-1:0]      drv_wdata;
    logic [NDRIVES-1:0]        drv_ack;
    logic [7:0]                drv_rdata;

    // Drive CPUs side.
    modport master (
        output drv_req, drv_we, drv_addr, drv_wdata,
        input  drv_ack, drv_rdata
    );

    // Arbiter side.
    modport slave (
        input  drv_req, drv_we, drv_addr, drv_wdata,
        output drv_ack, drv_rdata
    );
endinterface

// File: rtl/c1541_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; losers simply stay eligible for a later cycle.
module c1541_rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  elig,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          vld,
    output logic [PW-1:0] idx
);

    // Walk the ring starting at ptr; the first eligible index wins.
    always_comb begin
        grant = '0;
        vld   = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!vld && elig[(int'(ptr) + k) % N]) begin
                vld                          = 1'b1;
                grant[(int'(ptr) + k) % N]   = 1'b1;
                idx                          = PW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/c1541_rom_arbiter.sv
// Shares one drive-ROM port between NDRIVES 1541 CPUs and the host loader (optional C1541_ROM_ARB_STATS_EN adds stat_maxwait).
// Latency: req -> drv_ack exactly 2 cycles uncontested; worst case NDRIVES+1 without loader traffic.
// Backpressure: loader writes never stall and preempt drives; drives wait (req held) until their ack pulse.
module c1541_rom_arbiter
    import c1541_pkg::*;
#(
    parameter int NDRIVES = 4,
    parameter int ADDR_W  = ROM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    c1541_rom_arbiter_if.slave drv,
    input  logic              wr_enable,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic [1:0]        rom_sz,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_q
`ifdef C1541_ROM_ARB_STATS_EN
    ,
    output logic [NDRIVES*4-1:0] stat_maxwait
`endif
);

    localparam int PW = (NDRIVES > 1) ? $clog2(NDRIVES) : 1;

    rom_size_t          sz_q;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      ptr_nxt;
    logic [NDRIVES-1:0] inflight;
    logic [NDRIVES-1:0] elig;
    logic [NDRIVES-1:0] grant_oh;
    logic               grant_vld;
    logic [PW-1:0]      grant_idx;
    logic               drive_go;
    logic [ADDR_W-1:0]  win_addr;
    logic [7:0]         win_wdata;
    logic               win_we;
    logic               wr_ok;
    logic               s1_vld;
    logic [NDRIVES-1:0] s1_sel;

    assign rom_sz   = sz_q;
    assign elig     = drv.drv_req & ~inflight;
    // The loader takes the port outright; a drive winner only issues when it is idle.
    assign drive_go = grant_vld & ~ld_wr;
    assign ptr_nxt  = (grant_idx == PW'(NDRIVES - 1)) ? '0 : grant_idx + 1'b1;

    c1541_rr_pick #(
        .N  (NDRIVES),
        .PW (PW)
    ) u_pick (
        .elig  (elig),
        .ptr   (ptr),
        .grant (grant_oh),
        .vld   (grant_vld),
        .idx   (grant_idx)
    );

    // One-hot mux of the winning drive's address, data and write flag.
    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_we    = 1'b0;
        for (int i = 0; i < NDRIVES; i++) begin
            if (grant_oh[i]) begin
                win_addr  = drv.drv_addr[i*ADDR_W +: ADDR_W];
                win_wdata = drv.drv_wdata[i*8 +: 8];
                win_we    = drv.drv_we[i];
            end
        end
    end

    // Drive writes only land in the first 8 KB of a 32K (Dolphin) image; anything else degrades to a read.
    always_comb begin
        wr_ok = win_we & wr_enable & sz_q[1] & (win_addr[ADDR_W-1 -: 2] == DOLPHIN_WIN_BITS);
    end

    // Issue stage: register the memory request, track in-flight drives, advance the pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            ptr       <= '0;
            inflight  <= '0;
            s1_vld    <= 1'b0;
            s1_sel    <= '0;
            sz_q      <= SZ_8K;
        end else begin
            s1_vld   <= drive_go;
            s1_sel   <= drive_go ? grant_oh : '0;
            // Flag stays up through the ack cycle so a still-high req is not double-served.
            inflight <= (inflight & ~drv.drv_ack) | (drive_go ? grant_oh : '0);
            if (ld_wr) begin
                mem_addr  <= ld_addr;
                mem_wdata <= ld_data;
                mem_we    <= 1'b1;
                sz_q      <= rom_size_t'({ld_addr[ADDR_W-1], ld_addr[ADDR_W-1] | ld_addr[ADDR_W-2]});
            end else if (grant_vld) begin
                mem_addr  <= fold_addr(win_addr, sz_q);
                mem_wdata <= win_wdata;
                mem_we    <= wr_ok;
                ptr       <= ptr_nxt;
            end else begin
                mem_we    <= 1'b0;
            end
        end
    end

    // Response stage: memory data for the issued address is captured alongside the ack pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drv.drv_ack   <= '0;
            drv.drv_rdata <= '0;
        end else begin
            drv.drv_ack <= s1_vld ? s1_sel : '0;
            if (s1_vld) begin
                drv.drv_rdata <= mem_q;
            end
        end
    end

`ifdef C1541_ROM_ARB_STATS_EN
    logic [NDRIVES-1:0][3:0] wait_cnt;
    logic [NDRIVES-1:0][3:0] max_wait;

    assign stat_maxwait = max_wait;

    // Per-drive saturating wait counter; the running maximum is folded in at grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            max_wait <= '0;
        end else if (ld_wr && (ld_addr == '0)) begin
            wait_cnt <= '0;
            max_wait <= '0;
        end else begin
            for (int i = 0; i < NDRIVES; i++) begin
                if (drive_go && grant_oh[i]) begin
                    if (wait_cnt[i] > max_wait[i]) begin
                        max_wait[i] <= wait_cnt[i];
                    end
                    wait_cnt[i] <= '0;
                end else if (elig[i]) begin
                    if (wait_cnt[i] != 4'hF) begin
                        wait_cnt[i] <= wait_cnt[i] + 4'd1;
                    end
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_c1541_rom_arbiter.sv
// Bench for c1541_rom_arbiter: scoreboarded drive reads/writes against a behavioural ROM RAM.
// Latency: checks the 2-cycle uncontested req->ack path and contended/loader-delayed cases.
// Backpressure: requests are held until ack, then dropped in the ack cycle.
module tb_c1541_rom_arbiter;

    localparam int ND = 4;
    localparam int AW = 15;

    typedef struct {
        int         d;
        logic [7:0] data;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          wr_enable;
    logic          ld_wr;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic [1:0]    rom_sz;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic [7:0]    mem_q;
`ifdef C1541_ROM_ARB_STATS_EN
    logic [ND*4-1:0] stat_maxwait;
`endif

    logic [7:0] ram     [0:32767];
    logic [7:0] ref_mem [0:32767];
    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_chk = 0;
    int         n_err = 0;

    c1541_rom_arbiter_if #(.NDRIVES(ND), .ADDR_W(AW)) bus ();

    c1541_rom_arbiter #(.NDRIVES(ND), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .drv       (bus),
        .wr_enable (wr_enable),
        .ld_wr     (ld_wr),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .rom_sz    (rom_sz),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_q     (mem_q)
`ifdef C1541_ROM_ARB_STATS_EN
        ,
        .stat_maxwait (stat_maxwait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM RAM: writes on the clock edge, read data follows the registered address.
    assign mem_q = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops the scoreboard whenever an ack pulse is visible.
    always @(negedge clk) begin
        if (reset_n && bus.drv_ack != '0) begin
            if (exp_q.size() == 0) begin
                chk("ack_unexpected", 32'(bus.drv_ack), 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_ack_sel", 32'(bus.drv_ack), 32'(1) << mon_e.d);
                chk("sb_rdata", 32'(bus.drv_rdata), 32'(mon_e.data));
            end
        end
    end

    task automatic ld_write(input logic [AW-1:0] a, input logic [7:0] d);
        ld_wr   = 1'b1;
        ld_addr = a;
        ld_data = d;
        ref_mem[a] = d;
        tick();
        ld_wr = 1'b0;
    endtask

    task automatic drv_set(input int d, input logic we, input logic [AW-1:0] a, input logic [7:0] wd);
        bus.drv_req[d]           = 1'b1;
        bus.drv_we[d]            = we;
        bus.drv_addr[d*AW +: AW] = a;
        bus.drv_wdata[d*8 +: 8]  = wd;
    endtask

    task automatic drv_drop(input int d);
        bus.drv_req[d] = 1'b0;
        bus.drv_we[d]  = 1'b0;
    endtask

    task automatic push_exp(input int d, input logic [AW-1:0] a);
        exp_t e;
        e.d    = d;
        e.data = ref_mem[a];
        exp_q.push_back(e);
    endtask

    // Single uncontested access: memory request at t+1, ack at t+2.
    task automatic drv_access(input int d, input logic we, input logic [AW-1:0] a, input logic [7:0] wd,
                              input logic [AW-1:0] exp_addr, input logic exp_we, input string tag);
        push_exp(d, exp_addr);
        drv_set(d, we, a, wd);
        tick();
        chk({tag, "_maddr"}, 32'(mem_addr), 32'(exp_addr));
        chk({tag, "_mwe"}, 32'(mem_we), 32'(exp_we));
        if (exp_we) chk({tag, "_mwdata"}, 32'(mem_wdata), 32'(wd));
        tick();
        chk({tag, "_ack"}, 32'(bus.drv_ack), 32'(1) << d);
        drv_drop(d);
        if (exp_we) ref_mem[exp_addr] = wd;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < 32768; i++) begin
            ram[i]     = 8'(i) ^ 8'(i >> 8) ^ 8'hA5;
            ref_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'hA5;
        end
        reset_n       = 1'b0;
        wr_enable     = 1'b0;
        ld_wr         = 1'b0;
        ld_addr       = '0;
        ld_data       = '0;
        bus.drv_req   = '0;
        bus.drv_we    = '0;
        bus.drv_addr  = '0;
        bus.drv_wdata = '0;
        repeat (2) tick();

        chk("rst_ack", 32'(bus.drv_ack), 32'h0);
        chk("rst_rdata", 32'(bus.drv_rdata), 32'h0);
        chk("rst_mwe", 32'(mem_we), 32'h0);
        chk("rst_maddr", 32'(mem_addr), 32'h0);
        chk("rst_mwdata", 32'(mem_wdata), 32'h0);
        chk("rst_romsz", 32'(rom_sz), 32'h0);
        reset_n = 1'b1;
        tick();

        // Loader preload; last address 0x7FFF selects a 32K image.
        ld_write(15'h1234, 8'h5A);
        ld_write(15'h7FFF, 8'h00);
        chk("ld_romsz32", 32'(rom_sz), 32'h3);
        drv_access(0, 1'b0, 15'h1234, 8'h00, 15'h1234, 1'b0, "rd0");

        // Folding: 16K image then 8K image (drive 3 leaves the pointer at 0).
        ld_write(15'h3FFF, 8'h11);
        chk("ld_romsz16", 32'(rom_sz), 32'h1);
        drv_access(3, 1'b0, 15'h7ABC, 8'h00, 15'h3ABC, 1'b0, "fold16");
        ld_write(15'h1FFF, 8'h22);
        chk("ld_romsz8", 32'(rom_sz), 32'h0);
        drv_access(3, 1'b0, 15'h7ABC, 8'h00, 15'h1ABC, 1'b0, "fold8");

        // All four drives at once from pointer 0.
        ld_write(15'h7FFF, 8'h33);
        for (int i = 0; i < ND; i++) begin
            push_exp(i, 15'(16'h0010 + i));
            drv_set(i, 1'b0, 15'(16'h0010 + i), 8'h00);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k <= 4) chk("rr_maddr", 32'(mem_addr), 32'h10 + 32'(k - 1));
            if (k >= 2) begin
                chk("rr_ack", 32'(bus.drv_ack), 32'(1) << (k - 2));
                drv_drop(k - 2);
            end
        end
        tick();

        // Pointer must be back at 0: drive 0 beats drive 3.
        push_exp(0, 15'h0020);
        push_exp(3, 15'h0023);
        drv_set(0, 1'b0, 15'h0020, 8'h00);
        drv_set(3, 1'b0, 15'h0023, 8'h00);
        tick();
        chk("ptr_first", 32'(mem_addr), 32'h20);
        tick();
        chk("ptr_second", 32'(mem_addr), 32'h23);
        chk("ptr_ack0", 32'(bus.drv_ack), 32'h1);
        drv_drop(0);
        tick();
        chk("ptr_ack3", 32'(bus.drv_ack), 32'h8);
        drv_drop(3);
        tick();

        // Dolphin write window gating.
        wr_enable = 1'b1;
        drv_access(2, 1'b1, 15'h0100, 8'hEE, 15'h0100, 1'b1, "wr_ok");
        drv_access(2, 1'b0, 15'h0100, 8'h00, 15'h0100, 1'b0, "wr_readback");
        wr_enable = 1'b0;
        drv_access(2, 1'b1, 15'h0100, 8'h33, 15'h0100, 1'b0, "wr_noen");
        wr_enable = 1'b1;
        drv_access(2, 1'b1, 15'h4100, 8'h44, 15'h4100, 1'b0, "wr_outwin");
        ld_write(15'h3FFF, 8'h55);
        drv_access(2, 1'b1, 15'h0100, 8'h66, 15'h0100, 1'b0, "wr_16k");
        ld_write(15'h7FFF, 8'h00);
        wr_enable = 1'b0;

        // Loader and drive 1 in the same cycle: drive waits one cycle.
        push_exp(1, 15'h0200);
        drv_set(1, 1'b0, 15'h0200, 8'h00);
        ld_wr   = 1'b1;
        ld_addr = 15'h7FFE;
        ld_data = 8'h77;
        ref_mem[15'h7FFE] = 8'h77;
        tick();
        ld_wr = 1'b0;
        chk("ldpri_mwe", 32'(mem_we), 32'h1);
        chk("ldpri_maddr", 32'(mem_addr), 32'h7FFE);
        chk("ldpri_mwdata", 32'(mem_wdata), 32'h77);
        tick();
        chk("ldpri_drvaddr", 32'(mem_addr), 32'h0200);
        chk("ldpri_noack", 32'(bus.drv_ack), 32'h0);
        tick();
        chk("ldpri_ack", 32'(bus.drv_ack), 32'h2);
        drv_drop(1);
        tick();

        // Reset one cycle after a grant: access is discarded.
        drv_set(0, 1'b0, 15'h0300, 8'h00);
        tick();
        reset_n = 1'b0;
        #1;
        chk("mrst_ack", 32'(bus.drv_ack), 32'h0);
        chk("mrst_rdata", 32'(bus.drv_rdata), 32'h0);
        chk("mrst_maddr", 32'(mem_addr), 32'h0);
        chk("mrst_mwe", 32'(mem_we), 32'h0);
        chk("mrst_romsz", 32'(rom_sz), 32'h0);
        drv_drop(0);
        repeat (2) begin
            tick();
            chk("mrst_hold_ack", 32'(bus.drv_ack), 32'h0);
        end
        reset_n = 1'b1;
        repeat (2) tick();
        drv_access(0, 1'b0, 15'h0300, 8'h00, 15'h0300, 1'b0, "post_rst");

        repeat (4) tick();
        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
